// File: rtl/alu_ctrl_stage.sv
// Registered ALU-control decoder between ID and EX: decodes opcode/funct3/funct7
// into {m, b5, f3}, holds divide/remainder ops for DIV_CYCLES, and supports flush.
module alu_ctrl_stage #(
    parameter int CTRL_W     = 5,
    parameter int EN_M       = 1,
    parameter int DIV_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_control,
    output logic              illegal,
    output logic              multi_cycle
);

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LW    = 7'b0000011;
    localparam logic [6:0] OPC_SW    = 7'b0100011;
    localparam logic [6:0] OPC_J     = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    localparam int CNT_W    = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam int CNT_LOAD = (DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WAIT  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       ctrl_q;
    logic             illegal_q, multi_q;

    logic [4:0] dec_ctrl;
    logic       dec_illegal, dec_multi;
    logic       accept, load;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        dec_ctrl    = 5'b00000;
        dec_illegal = 1'b0;
        dec_multi   = 1'b0;
        case (opcode)
            OPC_R: begin
                if (funct7 == 7'h00) begin
                    dec_ctrl = {2'b00, funct3};
                end else if (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    dec_ctrl = {2'b01, funct3};
                end else if (EN_M != 0 && funct7 == 7'h01) begin
                    dec_ctrl  = {2'b10, funct3};
                    dec_multi = funct3[2];
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_I: begin
                case (funct3)
                    3'b001: begin
                        if (funct7 == 7'h00) dec_ctrl = {2'b00, funct3};
                        else                 dec_illegal = 1'b1;
                    end
                    3'b101: begin
                        if (funct7 == 7'h00 || funct7 == 7'h20) dec_ctrl = {1'b0, funct7[5], funct3};
                        else                                    dec_illegal = 1'b1;
                    end
                    default: dec_ctrl = {2'b00, funct3};
                endcase
            end
            OPC_LW, OPC_SW, OPC_J, OPC_JALR, OPC_AUIPC: dec_ctrl = 5'b00000;
            OPC_B:   dec_ctrl = 5'b01000;
            OPC_LUI: dec_ctrl = 5'b01111;
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_ctrl  = 5'b00000;
            dec_multi = 1'b0;
        end
    end

    assign in_ready  = (state_q == EMPTY) || (state_q == FULL && out_ready);
    assign out_valid = (state_q == FULL);
    assign accept    = in_valid && in_ready && !flush;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            EMPTY: load = accept;
            WAIT: begin
                if (cnt_q == '0) state_d = FULL;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            FULL: begin
                if (out_ready) begin
                    if (accept) load    = 1'b1;
                    else        state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (load) begin
            if (dec_multi && DIV_CYCLES > 1) begin
                state_d = WAIT;
                cnt_d   = CNT_W'(CNT_LOAD);
            end else begin
                state_d = FULL;
                cnt_d   = '0;
            end
        end
        // Flush overrides every transition, including a back-to-back reload.
        if (flush) begin
            state_d = EMPTY;
            cnt_d   = '0;
            load    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            cnt_q     <= '0;
            ctrl_q    <= 5'b00000;
            illegal_q <= 1'b0;
            multi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (flush) begin
                ctrl_q    <= 5'b00000;
                illegal_q <= 1'b0;
                multi_q   <= 1'b0;
            end else if (load) begin
                ctrl_q    <= dec_ctrl;
                illegal_q <= dec_illegal;
                multi_q   <= dec_multi;
            end
        end
    end

    assign alu_control = CTRL_W'(ctrl_q);
    assign illegal     = illegal_q;
    assign multi_cycle = multi_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed self-checking bench for alu_ctrl_stage; a second instance with
// EN_M = 0 shares the stimulus to cover M-extension encodings becoming illegal.
module tb_alu_ctrl_stage;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] alu_control;
    logic       illegal;
    logic       multi_cycle;

    logic       nm_in_ready;
    logic       nm_out_valid;
    logic [4:0] nm_alu_control;
    logic       nm_illegal;
    logic       nm_multi_cycle;

    int checks = 0;
    int errors = 0;

    alu_ctrl_stage #(.CTRL_W(5), .EN_M(1), .DIV_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_control(alu_control), .illegal(illegal), .multi_cycle(multi_cycle)
    );

    alu_ctrl_stage #(.CTRL_W(5), .EN_M(0), .DIV_CYCLES(4)) dut_nm (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(nm_in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .out_valid(nm_out_valid), .out_ready(out_ready),
        .alu_control(nm_alu_control), .illegal(nm_illegal), .multi_cycle(nm_multi_cycle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        in_valid = v;
        opcode   = op;
        funct3   = f3;
        funct7   = f7;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 7'h00, 3'b000, 7'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (out_valid !== 1'b0)        begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (alu_control !== 5'b00000)  begin errors++; $display("FAIL reset_alu_control: got %b want 00000", alu_control); end
        checks++; if (illegal !== 1'b0)          begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        checks++; if (multi_cycle !== 1'b0)      begin errors++; $display("FAIL reset_multi_cycle: got %b want 0", multi_cycle); end
        checks++; if (in_ready !== 1'b1)         begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [9] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011, 7'b0110011,
                                7'b0010011, 7'b0110111, 7'b1100011, 7'b1101111};
        logic [2:0] f3s [9] = '{3'b000, 3'b000, 3'b101, 3'b000, 3'b011, 3'b101, 3'b000, 3'b001, 3'b000};
        logic [6:0] f7s [9] = '{7'h00, 7'h20, 7'h20, 7'h7f, 7'h00, 7'h20, 7'h3a, 7'h55, 7'h12};
        logic [4:0] exp [9] = '{5'b00000, 5'b01000, 5'b01101, 5'b00000, 5'b00011,
                                5'b01101, 5'b01111, 5'b01000, 5'b00000};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, ops[i], f3s[i], f7s[i]);
            tick();
            checks++; if (out_valid !== 1'b1)    begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (alu_control !== exp[i]) begin errors++; $display("FAIL b2b_ctrl[%0d]: got %b want %b", i, alu_control, exp[i]); end
            checks++; if (illegal !== 1'b0)      begin errors++; $display("FAIL b2b_illegal[%0d]: got %b want 0", i, illegal); end
            checks++; if (in_ready !== 1'b1)     begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
        end
        drive(1'b0, 7'h00, 3'b000, 7'h00);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_div();
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 7'b0110011, 3'b100, 7'h01);
        tick();
        drive(1'b0, 7'h00, 3'b000, 7'h00);
        checks++; if (nm_out_valid !== 1'b1)       begin errors++; $display("FAIL nm_valid: got %b want 1", nm_out_valid); end
        checks++; if (nm_illegal !== 1'b1)         begin errors++; $display("FAIL nm_illegal: got %b want 1", nm_illegal); end
        checks++; if (nm_alu_control !== 5'b00000) begin errors++; $display("FAIL nm_ctrl: got %b want 00000", nm_alu_control); end
        checks++; if (nm_multi_cycle !== 1'b0)     begin errors++; $display("FAIL nm_multi: got %b want 0", nm_multi_cycle); end
        for (int k = 1; k <= 3; k++) begin
            #1;
            checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL div_in_ready[%0d]: got %b want 0", k, in_ready); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL div_wait_valid[%0d]: got %b want 0", k, out_valid); end
            tick();
        end
        checks++; if (out_valid !== 1'b1)       begin errors++; $display("FAIL div_valid: got %b want 1", out_valid); end
        checks++; if (alu_control !== 5'b10100) begin errors++; $display("FAIL div_ctrl: got %b want 10100", alu_control); end
        checks++; if (multi_cycle !== 1'b1)     begin errors++; $display("FAIL div_multi: got %b want 1", multi_cycle); end
        checks++; if (illegal !== 1'b0)         begin errors++; $display("FAIL div_illegal: got %b want 0", illegal); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL div_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 7'b0110011, 3'b000, 7'h20);
        tick();
        drive(1'b1, 7'b0110011, 3'b110, 7'h00);
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (out_valid !== 1'b1)       begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", k, out_valid); end
            checks++; if (alu_control !== 5'b01000) begin errors++; $display("FAIL stall_ctrl[%0d]: got %b want 01000", k, alu_control); end
            checks++; if (in_ready !== 1'b0)        begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", k, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1)       begin errors++; $display("FAIL stall_next_valid: got %b want 1", out_valid); end
        checks++; if (alu_control !== 5'b00110) begin errors++; $display("FAIL stall_next_ctrl: got %b want 00110", alu_control); end
        drive(1'b0, 7'h00, 3'b000, 7'h00);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 7'b0110011, 3'b100, 7'h01);
        tick();
        drive(1'b0, 7'h00, 3'b000, 7'h00);
        tick();
        flush = 1'b1;
        drive(1'b1, 7'b0110011, 3'b000, 7'h20);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_wait_ready: got %b want 0", in_ready); end
        tick();
        flush = 1'b0;
        drive(1'b0, 7'h00, 3'b000, 7'h00);
        #1;
        checks++; if (out_valid !== 1'b0)       begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1)        begin errors++; $display("FAIL flush_empty_ready: got %b want 1", in_ready); end
        checks++; if (alu_control !== 5'b00000) begin errors++; $display("FAIL flush_ctrl: got %b want 00000", alu_control); end
        checks++; if (multi_cycle !== 1'b0)     begin errors++; $display("FAIL flush_multi: got %b want 0", multi_cycle); end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_div[%0d]: got %b want 0", k, out_valid); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 7'b0110111, 3'b000, 7'h00);
        tick();
        drive(1'b0, 7'h00, 3'b000, 7'h00);
        checks++; if (alu_control !== 5'b01111) begin errors++; $display("FAIL arst_pre_ctrl: got %b want 01111", alu_control); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0)       begin errors++; $display("FAIL arst_valid: got %b want 0", out_valid); end
        checks++; if (alu_control !== 5'b00000) begin errors++; $display("FAIL arst_ctrl: got %b want 00000", alu_control); end
        checks++; if (in_ready !== 1'b1)        begin errors++; $display("FAIL arst_ready: got %b want 1", in_ready); end
        #1;
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        drive(1'b1, 7'b0000011, 3'b010, 7'h00);
        tick();
        drive(1'b0, 7'h00, 3'b000, 7'h00);
        checks++; if (out_valid !== 1'b1)       begin errors++; $display("FAIL arst_lw_valid: got %b want 1", out_valid); end
        checks++; if (alu_control !== 5'b00000) begin errors++; $display("FAIL arst_lw_ctrl: got %b want 00000", alu_control); end
        checks++; if (illegal !== 1'b0)         begin errors++; $display("FAIL arst_lw_illegal: got %b want 0", illegal); end
        tick();
    endtask

    task automatic test_illegal();
        logic [6:0] ops [4] = '{7'b1111111, 7'b0110011, 7'b0010011, 7'b0110011};
        logic [2:0] f3s [4] = '{3'b000, 3'b000, 3'b001, 3'b010};
        logic [6:0] f7s [4] = '{7'h00, 7'h10, 7'h20, 7'h20};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ops[i], f3s[i], f7s[i]);
            tick();
            checks++; if (illegal !== 1'b1)         begin errors++; $display("FAIL ill_flag[%0d]: got %b want 1", i, illegal); end
            checks++; if (alu_control !== 5'b00000) begin errors++; $display("FAIL ill_ctrl[%0d]: got %b want 00000", i, alu_control); end
            checks++; if (out_valid !== 1'b1)       begin errors++; $display("FAIL ill_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (multi_cycle !== 1'b0)     begin errors++; $display("FAIL ill_multi[%0d]: got %b want 0", i, multi_cycle); end
        end
        drive(1'b1, 7'b0110011, 3'b111, 7'h00);
        tick();
        checks++; if (illegal !== 1'b0)         begin errors++; $display("FAIL ill_clear: got %b want 0", illegal); end
        checks++; if (alu_control !== 5'b00111) begin errors++; $display("FAIL ill_and_ctrl: got %b want 00111", alu_control); end
        drive(1'b0, 7'h00, 3'b000, 7'h00);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ill_drain: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_div();
        test_stall();
        test_flush();
        test_async_reset();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
- Registered ALU-control decoder placed between the ID and EX stages of the pipelined RV32 core.
- Decodes opcode, funct3 and funct7 into an ALU operation code, then holds it in a valid/ready pipeline slot.
- Adds an optional M-extension mode; divide/remainder ops are held for a programmable number of cycles before being presented to EX.
- Adds flush support and an illegal-instruction flag.

Parameters:
- CTRL_W, 5, width of alu_control; must be >= 5; bits above [4] are always driven 0.
- EN_M, 1, 1 = decode RV32M (funct7 = 7'h01 on OP_R); 0 = such encodings are illegal.
- DIV_CYCLES, 4, cycles a DIV/DIVU/REM/REMU is held before out_valid; must be >= 1; 1 = no extra wait.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of the slot and of any in-progress wait
- in_valid  in  1  ID presents an instruction
- in_ready  out  1  stage accepts this cycle
- opcode  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7  in  7  instruction[31:25]
- out_valid  out  1  alu_control is valid for EX
- out_ready  in  1  EX consumes this cycle
- alu_control  out  CTRL_W  registered ALU op code
- illegal  out  1  registered: decoded instruction is unsupported
- multi_cycle  out  1  registered: slot holds an M-ext divide/remainder op

Behaviour:
- Encoding is alu_control[4:0] = {m, b5, f3}.
- OP_R (0110011):
  - funct7 = 00 gives {0,0,funct3}.
  - funct7 = 20 with funct3 = 000 or 101 gives {0,1,funct3}.
  - funct7 = 01 with EN_M = 1 gives {1,0,funct3}.
  - Any other combination is illegal.
- OP_I (0010011):
  - b5 = funct7[5] only when funct3 = 101 (SRAI/SRLI); otherwise b5 = 0.
  - funct3 = 001 requires funct7 = 00; funct3 = 101 requires funct7 = 00 or 20; anything else is illegal.
- OP_LW (0000011), OP_SW (0100011), OP_J (1101111), JALR (1100111), AUIPC (0010111) decode to ADD, 5'b00000.
- OP_B (1100011) decodes to SUB, 5'b01000.
- LUI (0110111) decodes to PASSB, 5'b01111.
- Any other opcode is illegal.
- Illegal instructions still occupy the slot: illegal = 1, alu_control = 0, multi_cycle = 0.
- multi_cycle = 1 only for an accepted M op with funct3[2] = 1.
- State machine, states EMPTY / WAIT / FULL:
  - in_ready = (state == EMPTY) | (state == FULL & out_ready); it is 0 in WAIT.
  - Accept = in_valid & in_ready & ~flush. On accept, the decoded fields register at the clock edge.
  - An accepted multi_cycle op with DIV_CYCLES > 1 goes to WAIT, with cnt loaded to DIV_CYCLES-2. Every other accepted op goes to FULL.
  - WAIT: out_valid = 0. cnt decrements each cycle. At cnt == 0 the next state is FULL.
  - FULL: out_valid = 1. If out_ready and no accept, go to EMPTY. If out_ready and accept, back-to-back reload and go to FULL or WAIT.
  - Without out_ready, outputs hold stable (no change while out_valid & ~out_ready).
- Latency:
  - 1 cycle from accept to out_valid for normal ops.
  - DIV_CYCLES cycles from accept to out_valid for divide/remainder ops.
- Throughput: 1 op per cycle when out_ready is held high.
- flush:
  - Has priority over accept and over all state transitions.
  - Next state = EMPTY, cnt = 0, out_valid = 0. alu_control, illegal and multi_cycle clear to 0.
  - in_ready may be high during flush, but nothing is captured.
- Reset (asynchronous assert; deassertion is externally synchronised):
  - state = EMPTY, cnt = 0.
  - alu_control = 0, illegal = 0, multi_cycle = 0, out_valid = 0.
  - in_ready = 1 on the first cycle after release.
  - Reset mid-WAIT abandons the op; nothing is emitted.
- cnt width = clog2(DIV_CYCLES) with a minimum of 1. cnt never wraps, because the decrement is gated at 0.

Test Plan:
- ADD/SUB/SRA/ADDI with funct7[5] = 1 and imm bit set, out_ready = 1 → alu_control 00000 / 01000 / 01101 / 00000, one cycle after accept, one op per cycle.
- DIV (opcode 0110011, funct7 01, funct3 100), DIV_CYCLES = 4 → in_ready low for 3 cycles; out_valid asserts 4 cycles after accept with alu_control 10100, multi_cycle = 1. Rerun with EN_M = 0 → illegal = 1, alu_control = 0, latency 1.
- FULL slot with out_ready = 0 for 5 cycles while ID presents the next op → outputs stable, in_ready = 0. out_ready = 1 → next op loaded the same edge, no bubble.
- flush asserted in WAIT (cnt = 1) together with in_valid → next cycle state EMPTY, out_valid = 0, nothing captured. The flushed DIV never appears.
- Async rst pulse mid-clock while FULL → outputs 0 immediately, without waiting for a clock edge. After release, LW (0000011) → alu_control 00000, illegal = 0.
- Opcode 7'b1111111 and OP_R with funct7 = 7'h10 → illegal = 1, alu_control = 0, out_valid = 1, normal handshake.
